mem_port_master: RTL

MEM_PORT_MASTER -- requirements
Module: mem_port_master

---
 rtl/mem_port_master.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_master.sv
// Load/store unit that turns one CPU byte/half/word request into accesses on a
// word-wide data memory; sub-word stores use a read-modify-write sequence.
module mem_port_master #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_regWrEn,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // req_ready is high only in IDLE; resp_valid is high only in RESP and the
    // response is held until resp_ready.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic        we_q,     we_d;
    logic [1:0]  size_q,   size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q,    off_d;
    logic [29:0] waddr_q,  waddr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rbuf_q,   rbuf_d;
    logic        err_q,    err_d;

    logic        accept;
    logic        req_err;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_ready = (state_q == S_IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    assign req_err = (req_size == 2'b11)
                  || ((req_size == 2'b01) && req_addr[0])
                  || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                  || ((req_addr[31:2] >> ADDR_WIDTH) != 30'd0);

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_addr[1:0];
                    waddr_d  = req_addr[31:2];
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (req_we && (req_size == 2'b10))
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                rbuf_d  = mem_dataOut;
                state_d = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            default: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    // Load lane extraction and store lane merge, both little-endian.
    always_comb begin
        shifted = rbuf_q >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
        merged = rbuf_q;
        case (size_q)
            2'b00:   merged[{off_q, 3'b000} +: 8]      = wdata_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign mem_regWrEn = (state_q == S_WRITE);
    assign mem_addr    = {2'b00, waddr_q};
    assign mem_dataIn  = (state_q == S_WRITE) ? merged : 32'd0;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_err    = (state_q == S_RESP) && err_q;
    assign resp_rdata  = ((state_q == S_RESP) && !we_q && !err_q) ? load_val : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            waddr_q  <= 30'd0;
            wdata_q  <= 32'd0;
            rbuf_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rbuf_q   <= rbuf_d;
            err_q    <= err_d;
        end
    end

endmodule
